// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop period.
// Paced by a 16x-oversample tick; start/busy/done handshake toward the result encoder.
module uart_tx #(
  parameter int DBIT    = 8,   // 5..8
  parameter int SB_TICK = 16,  // 16/24/32 -> 1/1.5/2 stop bits
  parameter int PARITY  = 0    // 0 none, 1 even, 2 odd
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_S, STOP} state_t;

  state_t     state, state_n;
  logic [4:0] s_cnt, s_cnt_n;
  logic [2:0] n_cnt, n_cnt_n;
  logic [7:0] b_reg, b_reg_n;
  logic       p_reg, p_reg_n;
  logic       tx_reg, tx_n;
  logic       done_reg, done_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      b_reg    <= '0;
      p_reg    <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_n;
      s_cnt    <= s_cnt_n;
      n_cnt    <= n_cnt_n;
      b_reg    <= b_reg_n;
      p_reg    <= p_reg_n;
      tx_reg   <= tx_n;
      done_reg <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_reg_n = b_reg;
    p_reg_n = p_reg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          b_reg_n = din;
          s_cnt_n = '0;
          n_cnt_n = '0;
          p_reg_n = (PARITY == 2);
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            s_cnt_n = '0;
            n_cnt_n = '0;
            state_n = DATA;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            p_reg_n = p_reg ^ b_reg[0];
            b_reg_n = b_reg >> 1;
            s_cnt_n = '0;
            if (n_cnt == 3'(DBIT - 1))
              state_n = (PARITY != 0) ? PARITY_S : STOP;
            else
              n_cnt_n = n_cnt + 3'd1;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end
      PARITY_S: begin
        if (s_tick) begin
          if (s_cnt == 5'd15) begin
            s_cnt_n = '0;
            state_n = STOP;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == 5'(SB_TICK - 1)) begin
            s_cnt_n = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level follows the next state so tx is registered yet aligned with the state change.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:    tx_n = 1'b0;
      DATA:     tx_n = b_reg_n[0];
      PARITY_S: tx_n = p_reg_n;
      default:  tx_n = 1'b1;
    endcase
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations run in lockstep against a
// frame-timeline reference model (tick index -> bit slot).
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] tx_w, busy_w, done_w;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_n (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_e (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
  uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY(2)) u_o (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of 16-tick slots; the line level is the slot's bit.
  int         dbv[3] = '{8, 8, 7};
  int         sbv[3] = '{16, 16, 32};
  int         pmv[3] = '{0, 1, 2};
  bit         m_busy[3];
  int         m_idx[3];
  logic [7:0] m_data[3];
  int         done_cnt[3];

  function automatic int flen(input int i);
    return 16 * (1 + dbv[i] + ((pmv[i] != 0) ? 1 : 0)) + sbv[i];
  endfunction

  function automatic logic exp_tx(input int i);
    int seg;
    if (!m_busy[i]) return 1'b1;
    seg = m_idx[i] / 16;
    if (seg == 0) return 1'b0;
    if (seg <= dbv[i]) return m_data[i][seg-1];
    if (pmv[i] != 0 && seg == dbv[i] + 1) return (^m_data[i]) ^ (pmv[i] == 2);
    return 1'b1;
  endfunction

  bit m_done[3];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0;
        m_idx[i]  <= 0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (tx_start) begin
            m_busy[i] <= 1'b1;
            m_idx[i]  <= 0;
            m_data[i] <= din & 8'((1 << dbv[i]) - 1);
          end
        end else if (s_tick) begin
          if (m_idx[i] == flen(i) - 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_idx[i] <= m_idx[i] + 1;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("tx%0d", i), 32'(tx_w[i]), 32'(exp_tx(i)));
        check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
        check($sformatf("done%0d", i), 32'(done_w[i]), 32'(m_done[i]));
        if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      end
    end
  end

  // Tick source: fixed period or random density.
  int tick_per = 1;
  int tick_ph = 0;
  bit tick_rand = 1'b0;
  always @(negedge clk) begin
    if (tick_rand) begin
      s_tick <= ($urandom_range(0, 2) == 0);
    end else begin
      s_tick  <= (tick_ph == 0);
      tick_ph <= (tick_ph + 1 >= tick_per) ? 0 : tick_ph + 1;
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  int d0[3];
  task automatic snap_done();
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
  endtask

  task automatic check_done(input string tag, input int n);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_done%0d", tag, i), 32'(done_cnt[i] - d0[i]), 32'(n));
  endtask

  initial begin
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_w), 32'h7);
    check("rst_busy", 32'(busy_w), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0x55 with a tick every cycle: busy for exactly one frame of 160 cycles.
    begin
      int blen = 0;
      snap_done();
      send(8'h55);
      while (busy_w[0] && blen < 1000) begin
        blen++;
        @(negedge clk);
      end
      check("busy_len", 32'(blen), 32'd160);
      wait_idle(1000);
      check_done("f55", 1);
    end

    // Parity frames on 0x07.
    snap_done();
    send(8'h07);
    wait_idle(1000);
    check_done("f07", 1);

    // Tick every 4 cycles: mid-bit decode of the line.
    begin
      logic [7:0] d = 8'h00;
      tick_per = 4;
      send(8'hA3);
      repeat (30) @(negedge clk);
      check("dec_start", 32'(tx_w[0]), 32'd0);
      for (int b = 0; b < 8; b++) begin
        repeat (64) @(negedge clk);
        d[b] = tx_w[0];
      end
      check("decode", 32'(d), 32'hA3);
      wait_idle(4000);
      tick_per = 1;
    end

    // Start request while busy is ignored.
    snap_done();
    send(8'h00);
    repeat (49) @(negedge clk);
    din = 8'hFF;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_idle(1000);
    check_done("ign", 1);

    // Back-to-back with tx_start held: line high gap = stop period + 1.
    begin
      int run = 0, gap = -1, n = 0;
      bit seen = 1'b0;
      snap_done();
      @(negedge clk);
      din = 8'h31;
      tx_start = 1'b1;
      @(negedge clk);
      din = 8'h32;
      while (gap < 0 && n < 1000) begin
        @(negedge clk);
        n++;
        if (tx_w[0]) run++;
        else begin
          if (seen) gap = run;
          run = 0;
        end
        if (done_w[0]) seen = 1'b1;
      end
      check("b2b_gap", 32'(gap), 32'd17);
      repeat (40) @(negedge clk);
      tx_start = 1'b0;
      wait_idle(1000);
      check_done("b2b", 2);
    end

    // Random data, random tick density, stray start pulses mid-frame.
    tick_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      snap_done();
      send(8'($urandom));
      repeat ($urandom_range(5, 300)) @(negedge clk);
      din = 8'($urandom);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_idle(6000);
      check_done("rnd", 1);
    end
    tick_rand = 1'b0;
    tick_per = 1;

    // Asynchronous reset in the middle of data bit 3, then a clean frame.
    send(8'hC3);
    repeat (70) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_tx", 32'(tx_w), 32'h7);
    check("arst_busy", 32'(busy_w), 32'h0);
    check("arst_done", 32'(done_w), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    snap_done();
    send(8'h5A);
    wait_idle(1000);
    check_done("f5a", 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

endmodule
